// File: rtl/rf_ctrl_pkg.sv
// rtl/rf_ctrl_pkg.sv - shared types and helpers for the regfile write-port controller
// Contents:
//   rf_ctrl_state_e : controller state (ST_INIT clear sequence, ST_RUN arbitration)
//   rf_gnt_e        : round-robin pointer / grant owner (GNT_A, GNT_B)
//   rf_other()      : returns the requester that is not the given one
package rf_ctrl_pkg;

    typedef enum logic {ST_INIT, ST_RUN} rf_ctrl_state_e;

    typedef enum logic {GNT_A, GNT_B} rf_gnt_e;

    function automatic rf_gnt_e rf_other(input rf_gnt_e g);
        return (g == GNT_A) ? GNT_B : GNT_A;
    endfunction

endpackage

// File: rtl/rf_rr_arb2.sv
// rtl/rf_rr_arb2.sv - two-way round-robin arbiter for the regfile write port
// Ports:
//   a_valid  in   requester A wants the port
//   b_valid  in   requester B wants the port
//   rr_ptr   in   owner of the tie-break this cycle
//   gnt_a    out  A granted (at most one grant high)
//   gnt_b    out  B granted
//   rr_next  out  pointer value to register; unchanged when nobody is granted
module rf_rr_arb2
    import rf_ctrl_pkg::*;
(
    input  logic    a_valid,
    input  logic    b_valid,
    input  rf_gnt_e rr_ptr,
    output logic    gnt_a,
    output logic    gnt_b,
    output rf_gnt_e rr_next
);

    always_comb begin
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        rr_next = rr_ptr;
        if (a_valid && b_valid) begin
            if (rr_ptr == GNT_A) begin
                gnt_a = 1'b1;
            end else begin
                gnt_b = 1'b1;
            end
            rr_next = rf_other(rr_ptr);
        end else if (a_valid) begin
            // A lone grant still hands priority to the other side.
            gnt_a   = 1'b1;
            rr_next = GNT_B;
        end else if (b_valid) begin
            gnt_b   = 1'b1;
            rr_next = GNT_A;
        end
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// rtl/rf_wb_ctrl.sv - write-port controller for regfile_2r1w (init clear + round-robin writeback)
// Optional feature macro: RF_WB_X0_DISCARD_EN (accepts to address 0 complete but never write)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_a_valid/addr/data      requester A write request
//   o_a_ready                A accepted this cycle (combinational)
//   i_b_valid/addr/data      requester B write request
//   o_b_ready                B accepted this cycle (combinational)
//   o_wen/o_waddr/o_wdata    regfile write port
//   o_busy                   high while the reset-time clear is running
module rf_wb_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int               ALEN     = 5,
    parameter int               DLEN     = 32,
    parameter logic [DLEN-1:0]  INIT_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_a_valid,
    input  logic [ALEN-1:0] i_a_addr,
    input  logic [DLEN-1:0] i_a_data,
    output logic            o_a_ready,
    input  logic            i_b_valid,
    input  logic [ALEN-1:0] i_b_addr,
    input  logic [DLEN-1:0] i_b_data,
    output logic            o_b_ready,
    output logic            o_wen,
    output logic [ALEN-1:0] o_waddr,
    output logic [DLEN-1:0] o_wdata,
    output logic            o_busy
);

    rf_ctrl_state_e  state;
    logic [ALEN-1:0] init_idx;
    rf_gnt_e         rr_ptr;
    rf_gnt_e         rr_next;
    logic            wen_q;
    logic [ALEN-1:0] waddr_q;
    logic [DLEN-1:0] wdata_q;
    logic            busy_q;

    logic            run;
    logic            gnt_a;
    logic            gnt_b;
    logic            accept;
    logic            issue;
    logic [ALEN-1:0] sel_addr;
    logic [DLEN-1:0] sel_data;

    // No handshake completes while reset is asserted: the accept would be lost.
    assign run = (state == ST_RUN) && !rst;

    rf_rr_arb2 u_arb (
        .a_valid (i_a_valid && run),
        .b_valid (i_b_valid && run),
        .rr_ptr  (rr_ptr),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .rr_next (rr_next)
    );

    assign o_a_ready = gnt_a;
    assign o_b_ready = gnt_b;
    assign accept    = gnt_a || gnt_b;
    assign sel_addr  = gnt_b ? i_b_addr : i_a_addr;
    assign sel_data  = gnt_b ? i_b_data : i_a_data;

`ifdef RF_WB_X0_DISCARD_EN
    // Entry 0 is hardwired: the requester sees a normal accept, the port stays idle.
    assign issue = accept && (sel_addr != '0);
`else
    assign issue = accept;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_idx <= '0;
            rr_ptr   <= GNT_A;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    wen_q    <= 1'b1;
                    waddr_q  <= init_idx;
                    wdata_q  <= INIT_VAL;
                    init_idx <= init_idx + 1'b1;
                    // busy drops on the same edge that registers the final clear write.
                    if (init_idx == '1) begin
                        state  <= ST_RUN;
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    wen_q  <= issue;
                    rr_ptr <= rr_next;
                    if (issue) begin
                        waddr_q <= sel_addr;
                        wdata_q <= sel_data;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // A write already registered when reset arrives must not reach the regfile,
    // so the enable is masked by rst in the same cycle.
    assign o_wen   = wen_q && !rst;
    assign o_waddr = waddr_q;
    assign o_wdata = wdata_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb/tb_rf_wb_ctrl.sv - self-checking bench for rf_wb_ctrl with a behavioural regfile
module tb_rf_wb_ctrl;

    localparam int ALEN  = 5;
    localparam int DLEN  = 32;
    localparam int DEPTH = 1 << ALEN;
`ifdef RF_WB_X0_DISCARD_EN
    localparam bit DISCARD = 1'b1;
`else
    localparam bit DISCARD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            i_a_valid;
    logic [ALEN-1:0] i_a_addr;
    logic [DLEN-1:0] i_a_data;
    logic            o_a_ready;
    logic            i_b_valid;
    logic [ALEN-1:0] i_b_addr;
    logic [DLEN-1:0] i_b_data;
    logic            o_b_ready;
    logic            o_wen;
    logic [ALEN-1:0] o_waddr;
    logic [DLEN-1:0] o_wdata;
    logic            o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DLEN-1:0] rf_mem  [DEPTH];
    logic [DLEN-1:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    rf_wb_ctrl #(.ALEN(ALEN), .DLEN(DLEN), .INIT_VAL('0)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_a_valid (i_a_valid),
        .i_a_addr  (i_a_addr),
        .i_a_data  (i_a_data),
        .o_a_ready (o_a_ready),
        .i_b_valid (i_b_valid),
        .i_b_addr  (i_b_addr),
        .i_b_data  (i_b_data),
        .o_b_ready (o_b_ready),
        .o_wen     (o_wen),
        .o_waddr   (o_waddr),
        .o_wdata   (o_wdata),
        .o_busy    (o_busy)
    );

    // Regfile stand-in: one synchronous write port, reads are array lookups.
    always @(posedge clk) begin
        if (o_wen === 1'b1) rf_mem[o_waddr] <= o_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_a_valid = 1'b0;
        i_b_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_wen", o_wen, 0);
        chk("rst_waddr", o_waddr, 0);
        chk("rst_wdata", o_wdata, 0);
        chk("rst_busy", o_busy, 1);
        chk("rst_ready_a", o_a_ready, 0);
        chk("rst_ready_b", o_b_ready, 0);
    endtask

    // Walk the clear: DEPTH consecutive writes of 0 to entries 0..DEPTH-1.
    task automatic run_init();
        for (int i = 0; i < DEPTH; i++) begin
            chk("init_ready_a", o_a_ready, 0);
            chk("init_ready_b", o_b_ready, 0);
            tick();
            chk("init_wen", o_wen, 1);
            chk("init_waddr", o_waddr, i);
            chk("init_wdata", o_wdata, 0);
            chk("init_busy", o_busy, (i == DEPTH - 1) ? 0 : 1);
        end
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    initial begin
        logic [DLEN-1:0] t3_a_data [4];
        logic [DLEN-1:0] t3_b_data [4];
        int              a_head;
        int              b_head;
        int              pref;

        rst       = 1'b1;
        i_a_valid = 1'b1;
        i_a_addr  = 5'd3;
        i_a_data  = 32'hA5A5_A5A5;
        i_b_valid = 1'b0;
        i_b_addr  = '0;
        i_b_data  = '0;
        for (int i = 0; i < DEPTH; i++) rf_mem[i] = 32'hFFFF_FFFF;

        // T1: one-cycle reset with A requesting throughout the clear
        do_reset();
        i_a_valid = 1'b1;
        run_init();
        tick();
        chk("t1_post_wen", o_wen, 0);
        for (int i = 0; i < DEPTH; i++) chk("t1_entry_zero", rf_mem[i], 0);

        // T2: lone A write
        i_a_valid = 1'b1; i_a_addr = 5'd5; i_a_data = 32'hDEAD_BEEF;
        #1;
        chk("t2_ready_a", o_a_ready, 1);
        chk("t2_ready_b", o_b_ready, 0);
        tick();
        idle_inputs();
        chk("t2_wen", o_wen, 1);
        chk("t2_waddr", o_waddr, 5);
        chk("t2_wdata", o_wdata, 32'hDEAD_BEEF);
        tick();
        chk("t2_wen_off", o_wen, 0);
        chk("t2_hold_addr", o_waddr, 5);
        chk("t2_entry5", rf_mem[5], 32'hDEAD_BEEF);

        // T5: A writes entry 0
        i_a_valid = 1'b1; i_a_addr = 5'd0; i_a_data = 32'h1234;
        #1;
        chk("t5_ready_a", o_a_ready, 1);
        tick();
        idle_inputs();
        chk("t5_wen", o_wen, DISCARD ? 0 : 1);
        tick();
        chk("t5_entry0", rf_mem[0], DISCARD ? 32'h0 : 32'h1234);

        // T6: accept B to entry 7, reset before the write reaches the regfile
        i_b_valid = 1'b1; i_b_addr = 5'd7; i_b_data = 32'h55;
        #1;
        chk("t6_ready_b", o_b_ready, 1);
        chk("t6_ready_a", o_a_ready, 0);
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("t6_wen_masked", o_wen, 0);
        tick();
        rst = 1'b0;
        chk("t6_wen_after", o_wen, 0);
        chk("t6_busy", o_busy, 1);
        chk("t6_entry7", rf_mem[7], 0);
        run_init();

        // T3: both requesters hold their heads until accepted; expect A,B,A,B
        a_head = 0; b_head = 0;
        for (int k = 0; k < 4; k++) begin
            t3_a_data[k] = $urandom;
            t3_b_data[k] = $urandom;
        end
        for (int k = 0; k < 4; k++) begin
            i_a_valid = 1'b1; i_a_addr = ALEN'(1 + a_head);  i_a_data = t3_a_data[a_head];
            i_b_valid = 1'b1; i_b_addr = ALEN'(11 + b_head); i_b_data = t3_b_data[b_head];
            #1;
            chk("t3_ready_a", o_a_ready, (k % 2 == 0) ? 1 : 0);
            chk("t3_ready_b", o_b_ready, (k % 2 == 1) ? 1 : 0);
            tick();
            chk("t3_wen", o_wen, 1);
            chk("t3_waddr", o_waddr, (k % 2 == 0) ? (1 + a_head) : (11 + b_head));
            if (k % 2 == 0) a_head++; else b_head++;
        end
        idle_inputs();
        tick();
        chk("t3_entry1", rf_mem[1], t3_a_data[0]);
        chk("t3_entry11", rf_mem[11], t3_b_data[0]);
        chk("t3_entry2", rf_mem[2], t3_a_data[1]);
        chk("t3_entry12", rf_mem[12], t3_b_data[1]);

        // T4: reset while the clear is at entry 10
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        chk("t4_waddr9", o_waddr, 9);
        rst = 1'b1;
        #1;
        chk("t4_wen_masked", o_wen, 0);
        tick();
        rst = 1'b0;
        chk("t4_restart_wen", o_wen, 0);
        chk("t4_restart_busy", o_busy, 1);
        run_init();

        // Random traffic against a reference: ties go to whichever side did
        // not win last; addresses biased low to exercise same-address ordering.
        pref = 0;
        for (int c = 0; c < 400; c++) begin
            logic exp_a, exp_b, exp_w;
            logic [ALEN-1:0] w_addr;
            logic [DLEN-1:0] w_data;
            i_a_valid = ($urandom_range(0, 2) != 0);
            i_b_valid = ($urandom_range(0, 2) != 0);
            i_a_addr  = ($urandom_range(0, 1) != 0) ? ALEN'($urandom_range(0, 3)) : ALEN'($urandom);
            i_b_addr  = ($urandom_range(0, 1) != 0) ? ALEN'($urandom_range(0, 3)) : ALEN'($urandom);
            i_a_data  = $urandom;
            i_b_data  = $urandom;
            exp_a = i_a_valid && (!i_b_valid || pref == 0);
            exp_b = i_b_valid && (!i_a_valid || pref == 1);
            if (exp_a) pref = 1;
            if (exp_b) pref = 0;
            w_addr = exp_b ? i_b_addr : i_a_addr;
            w_data = exp_b ? i_b_data : i_a_data;
            exp_w  = (exp_a || exp_b) && !(DISCARD && w_addr == 0);
            #1;
            chk("rnd_ready_a", o_a_ready, exp_a);
            chk("rnd_ready_b", o_b_ready, exp_b);
            tick();
            chk("rnd_wen", o_wen, exp_w);
            if (exp_w) begin
                chk("rnd_waddr", o_waddr, w_addr);
                chk("rnd_wdata", o_wdata, w_data);
                ref_mem[w_addr] = w_data;
            end
        end
        idle_inputs();
        tick();
        for (int i = 0; i < DEPTH; i++) chk("rnd_entry", rf_mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
